req_stream_packer: RTL and testbench

- Upstream feeder for the request-buffering stage.
- Accepts complete write commands (id, address, data) on a valid-ready interface and queues them in an internal FIFO.
- Serialises each command into a two-beat AXI-Stream packet: beat 0 carries the address, beat 1 carries the data, and tid is held constant across both beats.
- Its output connects directly to the buffering stage's req_tvalid/req_tid/req_tdata/req_tready inputs.

---
 rtl/req_stream_packer.sv | 121 ++++++++++++
 tb/tb_req_stream_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_stream_packer.sv
// Queues write commands and serialises each into a two-beat stream packet (addr beat, then data beat).
// A command reaches the address beat one cycle after its push edge; stream backpressure fills the FIFO and then drops cmd_ready_o.
module req_stream_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid_i,
  input  logic [2:0]               cmd_id_i,
  input  logic [15:0]              cmd_addr_i,
  input  logic [15:0]              cmd_data_i,
  output logic                     cmd_ready_o,
  output logic                     req_tvalid_o,
  output logic [2:0]               req_tid_o,
  output logic [15:0]              req_tdata_o,
  output logic                     req_tlast_o,
  input  logic                     req_tready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         sent_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  cmd_t             hold_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] sent_q;

  logic push, pop, fifo_empty, cnt_inc;

  // Ready looks at occupancy only, so a full FIFO never accepts even when a pop coincides.
  assign cmd_ready_o = (level_q < DEPTH_L);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign fifo_empty  = (level_q == '0);
  assign level_o     = level_q;
  assign sent_cnt_o  = sent_q;

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    cnt_inc      = 1'b0;
    req_tvalid_o = 1'b0;
    req_tid_o    = '0;
    req_tdata_o  = '0;
    req_tlast_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        req_tvalid_o = 1'b1;
        req_tid_o    = hold_q.id;
        req_tdata_o  = hold_q.addr;
        if (req_tready_i) state_d = S_DATA;
      end
      S_DATA: begin
        req_tvalid_o = 1'b1;
        req_tid_o    = hold_q.id;
        req_tdata_o  = hold_q.data;
        req_tlast_o  = 1'b1;
        if (req_tready_i) begin
          cnt_inc = 1'b1;
          // Reloading here keeps packets back to back with no idle cycle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
      sent_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (!push && pop) level_q <= level_q - LVL_W'(1);
      if (cnt_inc) sent_q <= sent_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{id: cmd_id_i, addr: cmd_addr_i, data: cmd_data_i};
  end

endmodule

// File: tb/tb_req_stream_packer.sv
// Directed and random stimulus for req_stream_packer, scored against a queue of expected beats.
module tb_req_stream_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_id = '0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic        tvalid;
  logic [2:0]  tid;
  logic [15:0] tdata;
  logic        tlast;
  logic        tready = 1'b0;
  logic [2:0]  level;
  logic [3:0]  sent_cnt;

  req_stream_packer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid), .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .cmd_ready_o(cmd_ready),
    .req_tvalid_o(tvalid), .req_tid_o(tid), .req_tdata_o(tdata), .req_tlast_o(tlast),
    .req_tready_i(tready),
    .level_o(level), .sent_cnt_o(sent_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] d;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cnt = 0;
  int    acc_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [2:0]  p_tid;
  logic [15:0] p_tdata;
  logic        p_tlast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted command owes an address beat then a data beat, in order.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable_tvalid", 32'(tvalid), 32'd1);
        chk("stable_tid",    32'(tid),    32'(p_tid));
        chk("stable_tdata",  32'(tdata),  32'(p_tdata));
        chk("stable_tlast",  32'(tlast),  32'(p_tlast));
      end
      if (tvalid && tready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("beat_content", 32'({tid, tdata, tlast}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        hs_cnt++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{id: cmd_id, d: cmd_addr, last: 1'b0});
        exp_q.push_back('{id: cmd_id, d: cmd_data, last: 1'b1});
        acc_cnt++;
      end
      prev_stall = tvalid && !tready;
      p_tid   = tid;
      p_tdata = tdata;
      p_tlast = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] id, input logic [15:0] addr, input logic [15:0] data,
                          output bit ok);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_data  = data;
    ok = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (cmd_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    tready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if (level == '0 && !tvalid) break;
      tick();
    end
    chk(tag, 32'(level == '0 && !tvalid), 32'd1);
  endtask

  initial begin
    bit ok;
    int h0;
    int acc;

    // Reset state
    tick();
    tick();
    chk("rst_tvalid",    32'(tvalid),    32'd0);
    chk("rst_tdata",     32'(tdata),     32'd0);
    chk("rst_tid",       32'(tid),       32'd0);
    chk("rst_tlast",     32'(tlast),     32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_sent",      32'(sent_cnt),  32'd0);
    reset = 1'b0;
    tick();

    // Single command and first-beat latency
    tready = 1'b1;
    push_cmd(3'd3, 16'h1234, 16'hBEEF, ok);
    chk("t1_push_ok",     32'(ok),     32'd1);
    chk("t1_tvalid_k",    32'(tvalid), 32'd0);
    chk("t1_level_k",     32'(level),  32'd1);
    tick();
    chk("t1_addr_tvalid", 32'(tvalid), 32'd1);
    chk("t1_addr_tid",    32'(tid),    32'd3);
    chk("t1_addr_tdata",  32'(tdata),  32'h1234);
    chk("t1_addr_tlast",  32'(tlast),  32'd0);
    chk("t1_level_pop",   32'(level),  32'd0);
    tick();
    chk("t1_data_tid",    32'(tid),    32'd3);
    chk("t1_data_tdata",  32'(tdata),  32'hBEEF);
    chk("t1_data_tlast",  32'(tlast),  32'd1);
    tick();
    chk("t1_idle_tvalid", 32'(tvalid),   32'd0);
    chk("t1_sent",        32'(sent_cnt), 32'd1);

    // Backpressure on both beats
    tready = 1'b0;
    h0 = hs_cnt;
    push_cmd(3'd5, 16'hA5A5, 16'h5A5A, ok);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr_tdata", 32'(tdata), 32'hA5A5);
      tick();
    end
    tready = 1'b1;
    tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data_tdata", 32'(tdata), 32'h5A5A);
      chk("bp_data_tlast", 32'(tlast), 32'd1);
      tick();
    end
    tready = 1'b1;
    tick();
    chk("bp_handshakes", 32'(hs_cnt - h0), 32'd2);
    chk("bp_sent",       32'(sent_cnt),    32'd2);

    // Back-to-back packets with no tvalid gap
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) push_cmd(3'(i), 16'($urandom), 16'($urandom), ok);
    chk("b2b_tvalid", 32'(tvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2b_tvalid", 32'(tvalid), 32'd1);
    end
    tick();
    chk("b2b_end_tvalid", 32'(tvalid),      32'd0);
    chk("b2b_handshakes", 32'(hs_cnt - h0), 32'd8);
    chk("b2b_sent",       32'(sent_cnt),    32'd6);

    // Full FIFO: four queued plus one held
    tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(3'(i + 1), 16'($urandom), 16'($urandom), ok);
      if (ok) acc++;
    end
    chk("full_accepts",   32'(acc),       32'd5);
    chk("full_level",     32'(level),     32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    drain("full_drain");
    chk("full_sent",      32'(sent_cnt),  32'd11);

    // Counter wrap at 4 bits
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 17; i++) push_cmd(3'($urandom), 16'($urandom), 16'($urandom), ok);
    drain("wrap_drain");
    chk("wrap_sent",  32'(sent_cnt),     32'd1);
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      cmd_valid = 1'($urandom % 2);
      cmd_id    = 3'($urandom);
      cmd_addr  = 16'($urandom);
      cmd_data  = 16'($urandom);
      tready    = ($urandom % 4) != 0;
      tick();
    end
    cmd_valid = 1'b0;
    drain("rnd_drain");
    chk("rnd_sent",  32'(sent_cnt),     32'(acc_cnt % 16));
    chk("rnd_queue", 32'(exp_q.size()), 32'd0);

    // Reset during the data beat with two commands queued
    tready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(3'(i + 4), 16'($urandom), 16'($urandom), ok);
    chk("rm_level_pre", 32'(level), 32'd2);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("rm_in_data", 32'(tlast), 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_tvalid",    32'(tvalid),    32'd0);
    chk("rm_tdata",     32'(tdata),     32'd0);
    chk("rm_tid",       32'(tid),       32'd0);
    chk("rm_tlast",     32'(tlast),     32'd0);
    chk("rm_level",     32'(level),     32'd0);
    chk("rm_sent",      32'(sent_cnt),  32'd0);
    chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    reset  = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rm_quiet_tvalid", 32'(tvalid), 32'd0);
    end
    push_cmd(3'd7, 16'h0F0F, 16'hF0F0, ok);
    tick();
    chk("rm_new_tvalid", 32'(tvalid), 32'd1);
    chk("rm_new_tdata",  32'(tdata),  32'h0F0F);
    drain("rm_drain");
    chk("rm_sent_after", 32'(sent_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
